// File: rtl/alu_issue.sv
// Purpose : single-issue RV32 ALU sequencer. It holds a 32x32 register file,
//           decodes R/I-type ALU ops, drives an external combinational ALU,
//           and writes the result back.
// Latency : accept on edge N, wb_valid high in the cycle that closes at edge N+3,
//           next accept no earlier than edge N+4.
// Backpr. : o_instr_ready is high only in IDLE, so one instruction is in flight at a time.
//
// Ports:
//   i_clk, i_rst                 clock and synchronous active-high reset
//   i_instr_valid / i_instr      instruction offer; o_instr_ready accepts it
//   o_alu_a/b, o_alu_funct3/7    registered operands and operation to the ALU
//   i_alu_out                    combinational ALU result
//   o_wb_valid/o_wb_rd/o_wb_data write-back pulse, destination and value
//   o_illegal                    one-cycle pulse for a rejected instruction
//   o_retired                    count of write-backs (wraps at 32 bits)
//   i_dbg_addr / o_dbg_data      combinational register-file debug read
module alu_issue #(
  parameter logic [31:0] REG_INIT = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_instr_valid,
  input  logic [31:0] i_instr,
  output logic        o_instr_ready,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [2:0]  o_alu_funct3,
  output logic [6:0]  o_alu_funct7,
  input  logic [31:0] i_alu_out,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_illegal,
  output logic [31:0] o_retired,
  input  logic [4:0]  i_dbg_addr,
  output logic [31:0] o_dbg_data
);

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_accept;

  logic [31:0] r_instr;
  logic [31:0] r_regs [32];
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [2:0]  r_alu_funct3;
  logic [6:0]  r_alu_funct7;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_illegal;
  logic [31:0] r_retired;

  // Decode fields of the latched instruction.
  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [31:0] w_imm;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic        w_is_r;
  logic        w_is_i;
  logic        w_f3_ok;
  logic        w_legal;

  assign w_opcode = r_instr[6:0];
  assign w_rd     = r_instr[11:7];
  assign w_f3     = r_instr[14:12];
  assign w_rs1    = r_instr[19:15];
  assign w_rs2    = r_instr[24:20];
  assign w_f7     = r_instr[31:25];
  assign w_imm    = {{20{r_instr[31]}}, r_instr[31:20]};

  // x0 is forced to zero on read so its storage never matters.
  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];

  assign w_is_r  = (w_opcode == OP_RTYPE);
  assign w_is_i  = (w_opcode == OP_ITYPE);
  // Supported ops: ADD/SUB(0), SLL(1), XOR(4), OR(6), AND(7).
  assign w_f3_ok = (w_f3 == 3'd0) || (w_f3 == 3'd1) || (w_f3 == 3'd4) ||
                   (w_f3 == 3'd6) || (w_f3 == 3'd7);

  // R-type: funct7 0x20 only selects SUB. I-type: the upper imm bits
  // of a shift must be zero (SRAI-style encodings are rejected), and
  // funct3 0 is always ADDI whatever the immediate holds.
  always_comb begin
    w_legal = 1'b0;
    if (w_is_r) begin
      w_legal = w_f3_ok &&
                ((w_f7 == 7'h00) || ((w_f7 == 7'h20) && (w_f3 == 3'd0)));
    end else if (w_is_i) begin
      w_legal = w_f3_ok && ((w_f3 != 3'd1) || (w_f7 == 7'h00));
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_instr_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: w_state_nxt = w_legal ? S_EXEC : S_IDLE;
      S_EXEC:   w_state_nxt = S_WB;
      S_WB:     w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and register file.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_instr      <= 32'd0;
      r_alu_a      <= 32'd0;
      r_alu_b      <= 32'd0;
      r_alu_funct3 <= 3'd0;
      r_alu_funct7 <= 7'd0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= 5'd0;
      r_wb_data    <= 32'd0;
      r_illegal    <= 1'b0;
      r_retired    <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= (i == 0) ? 32'd0 : REG_INIT;
      end
    end else begin
      // Both flags are single-cycle pulses by default.
      r_wb_valid <= 1'b0;
      r_illegal  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_instr <= i_instr;
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_alu_a      <= w_rs1_val;
            r_alu_b      <= w_is_r ? w_rs2_val : w_imm;
            r_alu_funct3 <= w_f3;
            r_alu_funct7 <= w_is_r ? w_f7 : 7'h00;
          end else begin
            // Rejected: operands stay as they were, only the pulse fires.
            r_illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          r_wb_rd    <= w_rd;
          r_wb_data  <= i_alu_out;
          r_wb_valid <= 1'b1;
        end
        S_WB: begin
          if (r_wb_rd != 5'd0) begin
            r_regs[r_wb_rd] <= r_wb_data;
          end
          r_retired <= r_retired + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_instr_ready = (r_state == S_IDLE);
  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_funct3  = r_alu_funct3;
  assign o_alu_funct7  = r_alu_funct7;
  assign o_wb_valid    = r_wb_valid;
  assign o_wb_rd       = r_wb_rd;
  assign o_wb_data     = r_wb_data;
  assign o_illegal     = r_illegal;
  assign o_retired     = r_retired;
  assign o_dbg_data    = (i_dbg_addr == 5'd0) ? 32'd0 : r_regs[i_dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Purpose : directed self-checking bench for alu_issue with a behavioural ALU.
// Latency : expects wb_valid in the cycle closing at edge N+3 after acceptance at edge N.
// Backpr. : offers instructions only while o_instr_ready is high; one test holds valid high.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        instr_ready;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic        wb_valid, illegal;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, retired;
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_data;

  int errors = 0;
  int checks = 0;

  // Observations collected by the driver for the current instruction.
  int          s_lat;
  logic        s_wb, s_ill, s_rdy_ill;
  logic [31:0] s_a, s_b, s_wdat;
  logic [6:0]  s_f7;
  logic [4:0]  s_wrd;

  always #5 clk = ~clk;

  alu_issue #(.REG_INIT(32'hA5A5_A5A5)) dut (
    .i_clk(clk), .i_rst(rst), .i_instr_valid(instr_valid), .i_instr(instr),
    .o_instr_ready(instr_ready), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .o_alu_funct3(alu_funct3), .o_alu_funct7(alu_funct7), .i_alu_out(alu_out),
    .o_wb_valid(wb_valid), .o_wb_rd(wb_rd), .o_wb_data(wb_data),
    .o_illegal(illegal), .o_retired(retired),
    .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data)
  );

  // External ALU: ADD/SUB, SLL, XOR, OR, AND.
  always_comb begin
    alu_out = 32'd0;
    case (alu_funct3)
      3'd0: alu_out = alu_funct7[5] ? (alu_a - alu_b) : (alu_a + alu_b);
      3'd1: alu_out = alu_a << alu_b[4:0];
      3'd4: alu_out = alu_a ^ alu_b;
      3'd6: alu_out = alu_a | alu_b;
      3'd7: alu_out = alu_a & alu_b;
      default: alu_out = 32'd0;
    endcase
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // Offers one instruction, then watches up to 8 edges for wb_valid or illegal.
  // s_lat counts edges from acceptance to the edge that closes the wb_valid cycle.
  task automatic drive(input logic [31:0] ins);
    int n;
    s_lat = 0; s_wb = 1'b0; s_ill = 1'b0; s_rdy_ill = 1'b0;
    s_a = 32'hX; s_b = 32'hX; s_f7 = 7'hX; s_wdat = 32'hX; s_wrd = 5'hX;
    @(negedge clk);
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    for (int k = 1; k <= 8 && !s_wb && !s_ill; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        s_a = alu_a; s_b = alu_b; s_f7 = alu_funct7;
      end
      if (wb_valid) begin
        s_wb = 1'b1; s_lat = k + 1; s_wdat = wb_data; s_wrd = wb_rd;
      end
      if (illegal) begin
        s_ill = 1'b1; s_rdy_ill = instr_ready;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({wb_valid, illegal, instr_ready} !== 3'b001) begin errors++;
      $display("FAIL reset_flags: got %b want 001", {wb_valid, illegal, instr_ready}); end
    checks++; if ({alu_a, alu_b, alu_funct3, alu_funct7} !== 74'd0) begin errors++;
      $display("FAIL reset_alu: got a=%h b=%h f3=%h f7=%h want 0", alu_a, alu_b, alu_funct3, alu_funct7); end
    checks++; if ({wb_rd, wb_data, retired} !== 69'd0) begin errors++;
      $display("FAIL reset_wb: got rd=%h data=%h ret=%h want 0", wb_rd, wb_data, retired); end
    dbg_addr = 5'd1; #1;
    checks++; if (dbg_data !== 32'hA5A5_A5A5) begin errors++;
      $display("FAIL reset_x1: got %h want a5a5a5a5", dbg_data); end
    dbg_addr = 5'd31; #1;
    checks++; if (dbg_data !== 32'hA5A5_A5A5) begin errors++;
      $display("FAIL reset_x31: got %h want a5a5a5a5", dbg_data); end
    dbg_addr = 5'd0; #1;
    checks++; if (dbg_data !== 32'd0) begin errors++;
      $display("FAIL reset_x0: got %h want 0", dbg_data); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_addi_add;
    drive(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'b0010011));
    checks++; if (s_lat !== 3) begin errors++; $display("FAIL addi1_lat: got %0d want 3", s_lat); end
    checks++; if ({s_wrd, s_wdat} !== {5'd1, 32'd5}) begin errors++;
      $display("FAIL addi1_wb: got rd=%0d data=%h want rd=1 data=5", s_wrd, s_wdat); end
    drive(enc_i(12'd3, 5'd0, 3'd0, 5'd2, 7'b0010011));
    checks++; if (s_lat !== 3) begin errors++; $display("FAIL addi2_lat: got %0d want 3", s_lat); end
    checks++; if (s_wdat !== 32'd3) begin errors++; $display("FAIL addi2_data: got %h want 3", s_wdat); end
    drive(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    checks++; if (s_lat !== 3) begin errors++; $display("FAIL add_lat: got %0d want 3", s_lat); end
    checks++; if (s_wdat !== 32'd8) begin errors++; $display("FAIL add_data: got %h want 8", s_wdat); end
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL wb_pulse_width: got %b want 0", wb_valid); end
    dbg_addr = 5'd3; #1;
    checks++; if (dbg_data !== 32'd8) begin errors++; $display("FAIL dbg_x3: got %h want 8", dbg_data); end
    checks++; if (retired !== 32'd3) begin errors++; $display("FAIL retired3: got %0d want 3", retired); end
  endtask

  task automatic test_sub_neg;
    drive(enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd4));
    checks++; if ({s_a, s_b, s_f7} !== {32'd3, 32'd5, 7'h20}) begin errors++;
      $display("FAIL sub_ops: got a=%h b=%h f7=%h want 3 5 20", s_a, s_b, s_f7); end
    checks++; if (s_wdat !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_data: got %h want fffffffe", s_wdat); end
    drive(enc_i(12'hFFF, 5'd0, 3'd0, 5'd5, 7'b0010011));
    checks++; if ({s_b, s_f7} !== {32'hFFFF_FFFF, 7'h00}) begin errors++;
      $display("FAIL addi_neg_ops: got b=%h f7=%h want ffffffff 00", s_b, s_f7); end
    checks++; if (s_wdat !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_neg_data: got %h want ffffffff", s_wdat); end
  endtask

  task automatic test_slli;
    logic saw_wb;
    drive(enc_i({7'h00, 5'd4}, 5'd1, 3'd1, 5'd6, 7'b0010011));
    checks++; if ({s_wb, s_wdat} !== {1'b1, 32'h50}) begin errors++;
      $display("FAIL slli_data: got vld=%b data=%h want 1 50", s_wb, s_wdat); end
    drive(enc_i({7'h20, 5'd4}, 5'd1, 3'd1, 5'd6, 7'b0010011));
    checks++; if ({s_ill, s_wb} !== 2'b10) begin errors++;
      $display("FAIL slli_bad_ill: got ill=%b wb=%b want 1 0", s_ill, s_wb); end
    checks++; if ({s_a, s_b} !== {32'd5, 32'd4}) begin errors++;
      $display("FAIL slli_bad_alu_hold: got a=%h b=%h want 5 4", s_a, s_b); end
    saw_wb = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (wb_valid) saw_wb = 1'b1; end
    checks++; if (saw_wb !== 1'b0) begin errors++; $display("FAIL slli_bad_no_wb: got %b want 0", saw_wb); end
    dbg_addr = 5'd6; #1;
    checks++; if (dbg_data !== 32'h50) begin errors++; $display("FAIL slli_bad_x6: got %h want 50", dbg_data); end
    checks++; if (retired !== 32'd6) begin errors++; $display("FAIL slli_bad_retired: got %0d want 6", retired); end
  endtask

  task automatic test_illegal;
    drive(enc_i(12'd0, 5'd1, 3'd2, 5'd1, 7'b0000011));
    checks++; if ({s_ill, s_rdy_ill, s_wb} !== 3'b110) begin errors++;
      $display("FAIL load_ill: got ill=%b rdy=%b wb=%b want 1 1 0", s_ill, s_rdy_ill, s_wb); end
    dbg_addr = 5'd1; #1;
    checks++; if (dbg_data !== 32'd5) begin errors++; $display("FAIL load_x1_kept: got %h want 5", dbg_data); end
    drive(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd9));
    checks++; if ({s_ill, s_rdy_ill, s_wb} !== 3'b110) begin errors++;
      $display("FAIL rf3_2_ill: got ill=%b rdy=%b wb=%b want 1 1 0", s_ill, s_rdy_ill, s_wb); end
    drive(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd0));
    checks++; if ({s_wb, s_wrd, s_wdat} !== {1'b1, 5'd0, 32'd10}) begin errors++;
      $display("FAIL add_x0_wb: got vld=%b rd=%0d data=%h want 1 0 a", s_wb, s_wrd, s_wdat); end
    @(posedge clk); #1;
    dbg_addr = 5'd0; #1;
    checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL x0_zero: got %h want 0", dbg_data); end
    checks++; if (retired !== 32'd7) begin errors++; $display("FAIL retired7: got %0d want 7", retired); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q [3];
    int acc [3];
    int idx, nrdy, nwb;
    logic took;
    q[0] = enc_i(12'd1, 5'd0, 3'd0, 5'd8, 7'b0010011);
    q[1] = enc_i(12'd2, 5'd0, 3'd0, 5'd9, 7'b0010011);
    q[2] = enc_i(12'd3, 5'd0, 3'd0, 5'd10, 7'b0010011);
    acc[0] = -100; acc[1] = -100; acc[2] = -100;
    idx = 0; nrdy = 0; nwb = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    instr = q[0];
    instr_valid = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (wb_valid) nwb++;
      took = instr_valid && instr_ready;
      if (took) begin acc[idx] = cyc; nrdy++; end
      @(posedge clk);
      #1;
      if (took) begin
        idx++;
        if (idx < 3) instr = q[idx];
        else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    checks++; if (nrdy !== 3) begin errors++; $display("FAIL b2b_accepts: got %0d want 3", nrdy); end
    checks++; if ((acc[1] - acc[0]) !== 4 || (acc[2] - acc[1]) !== 4) begin errors++;
      $display("FAIL b2b_spacing: got %0d %0d want 4 4", acc[1] - acc[0], acc[2] - acc[1]); end
    checks++; if (nwb !== 3) begin errors++; $display("FAIL b2b_wb_count: got %0d want 3", nwb); end
    dbg_addr = 5'd9; #1;
    checks++; if (dbg_data !== 32'd2) begin errors++; $display("FAIL b2b_x9: got %h want 2", dbg_data); end
    dbg_addr = 5'd10; #1;
    checks++; if (dbg_data !== 32'd3) begin errors++; $display("FAIL b2b_x10: got %h want 3", dbg_data); end
    checks++; if (retired !== 32'd10) begin errors++; $display("FAIL retired10: got %0d want 10", retired); end
  endtask

  task automatic test_reset_mid;
    logic saw_wb;
    int n;
    @(negedge clk);
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    instr = enc_i(12'd9, 5'd0, 3'd0, 5'd7, 7'b0010011);
    instr_valid = 1'b1;
    @(posedge clk);          // accepted, DECODE follows
    #1 instr_valid = 1'b0;
    @(posedge clk);          // now in EXEC
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({wb_valid, retired, wb_data, alu_a} !== 97'd0) begin errors++;
      $display("FAIL rst_mid_state: got wb=%b ret=%h data=%h a=%h want 0", wb_valid, retired, wb_data, alu_a); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", instr_ready); end
    saw_wb = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (wb_valid) saw_wb = 1'b1; end
    checks++; if (saw_wb !== 1'b0) begin errors++; $display("FAIL rst_mid_no_wb: got %b want 0", saw_wb); end
    dbg_addr = 5'd7; #1;
    checks++; if (dbg_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL rst_mid_x7: got %h want a5a5a5a5", dbg_data); end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL rst_mid_retired: got %0d want 0", retired); end
  endtask

  initial begin
    test_reset();
    test_addi_add();
    test_sub_neg();
    test_slli();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
